// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: pipelined carry-select adder/subtractor.
// WIDTH bits are resolved BLOCK bits per stage over NBLK = WIDTH/BLOCK
// register stages. Each stage builds both candidate block sums and lets the
// carry registered by the previous stage pick one. Operand blocks not yet
// consumed are skew-buffered alongside the growing low part of the result.
// Flow control is one global enable: the whole pipe advances or holds.
// Optional feature macro: CSEL_OVF_EN adds the out_ovf signed-overflow output.
// WIDTH must be a multiple of BLOCK.
module pipelined_csel_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CSEL_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int NBLK = WIDTH / BLOCK;

    // The pipe advances when the output slot is empty or being drained.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        // OPW: operand bits still unresolved on entry; SW: result bits known on exit.
        localparam int OPW = WIDTH - k * BLOCK;
        localparam int SW  = (k + 1) * BLOCK;

        logic           w_vin;
        logic           w_cin;
        logic [OPW-1:0] w_a;
        logic [OPW-1:0] w_b;
        logic [BLOCK:0] w_s0;
        logic [BLOCK:0] w_s1;
        logic [BLOCK:0] w_sel;
        logic [SW-1:0]  w_sum_nx;

        logic           r_vld;
        logic           r_cy;
        logic [SW-1:0]  r_sum;

        if (k == 0) begin : g_in
            // Subtract is A + ~B + 1; the forced carry-in overrides in_cin.
            assign w_vin    = in_valid & w_en;
            assign w_cin    = in_sub | in_cin;
            assign w_a      = in_a;
            assign w_b      = in_sub ? ~in_b : in_b;
            assign w_sum_nx = w_sel[BLOCK-1:0];
        end else begin : g_in
            assign w_vin    = g_stg[k-1].r_vld;
            assign w_cin    = g_stg[k-1].r_cy;
            assign w_a      = g_stg[k-1].g_op.r_a;
            assign w_b      = g_stg[k-1].g_op.r_b;
            assign w_sum_nx = {w_sel[BLOCK-1:0], g_stg[k-1].r_sum};
        end

        // Both candidates are formed without waiting on the carry; the carry only drives the mux.
        assign w_s0  = {1'b0, w_a[BLOCK-1:0]} + {1'b0, w_b[BLOCK-1:0]};
        assign w_s1  = {1'b0, w_a[BLOCK-1:0]} + {1'b0, w_b[BLOCK-1:0]} + {{BLOCK{1'b0}}, 1'b1};
        assign w_sel = w_cin ? w_s1 : w_s0;

        // Stage valid, selected carry and accumulated result advance together on enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_sum <= '0;
            end else if (w_en) begin
                r_vld <= w_vin;
                r_cy  <= w_sel[BLOCK];
                r_sum <= w_sum_nx;
            end
        end

        if (k < NBLK - 1) begin : g_op
            logic [OPW-BLOCK-1:0] r_a;
            logic [OPW-BLOCK-1:0] r_b;

            // Skew buffer: carry the unconsumed upper operand blocks to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a[OPW-1:BLOCK];
                    r_b <= w_b[OPW-1:BLOCK];
                end
            end
        end
    end

    assign out_valid = g_stg[NBLK-1].r_vld;
    assign out_sum   = g_stg[NBLK-1].r_sum;
    assign out_cout  = g_stg[NBLK-1].r_cy;

`ifdef CSEL_OVF_EN
    // Carry into the MSB recovered as a ^ b ^ sum at that bit of the last block.
    logic w_cmsb;
    logic r_ovf;
    assign w_cmsb = g_stg[NBLK-1].w_a[BLOCK-1] ^ g_stg[NBLK-1].w_b[BLOCK-1]
                  ^ g_stg[NBLK-1].w_sel[BLOCK-1];

    // Signed overflow registered with the final stage so it stalls with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_cmsb ^ g_stg[NBLK-1].w_sel[BLOCK];
        end
    end
    assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder (WIDTH=32, BLOCK=8).
// A queue-based arithmetic model predicts every result; directed vectors
// also carry hand-computed literal expectations.
module tb_pipelined_csel_adder;
    localparam int NBLK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b0;
    wire         in_ready;
    wire         out_valid;
    wire  [31:0] out_sum;
    wire         out_cout;
`ifdef CSEL_OVF_EN
    wire         out_ovf;
`endif

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
`ifdef CSEL_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        has_lit;
        logic [31:0] lsum;
        logic        lcout;
        logic        lovf;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic        cur_has = 1'b0;
    logic [31:0] cur_lsum = '0;
    logic        cur_lcout = 1'b0;
    logic        cur_lovf = 1'b0;

    int          mode = 0;
    logic [7:0]  pat = 8'b0110_1001;
    int          pi = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: what the adder must produce.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t            e;
        longint unsigned t;
        longint          sr;
        e = '{default: '0};
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            sr     = longint'($signed(a)) - longint'($signed(b));
        end else begin
            t      = longint'(a) + longint'(b) + longint'(cin);
            e.sum  = t[31:0];
            e.cout = (t >= 64'h1_0000_0000);
            sr     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    // out_ready driver
    always @(posedge clk) begin
        #1;
        case (mode)
            0: out_ready = 1'b1;
            1: begin out_ready = pat[pi % 8]; pi++; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process: transfers, flow-control rule, stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_sum = '0;
    logic        prev_cout = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_sum", out_sum, prev_sum);
                chk("stall_cout", out_cout, prev_cout);
            end
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: got sum %0h expected no result", out_sum);
                end else begin
                    e = q.pop_front();
                    chk("sum", out_sum, e.sum);
                    chk("cout", out_cout, e.cout);
`ifdef CSEL_OVF_EN
                    chk("ovf", out_ovf, e.ovf);
`endif
                    if (e.has_lit) begin
                        chk("lit_sum", out_sum, e.lsum);
                        chk("lit_cout", out_cout, e.lcout);
`ifdef CSEL_OVF_EN
                        chk("lit_ovf", out_ovf, e.lovf);
`endif
                    end
                end
            end
            if (in_valid && in_ready) begin
                e         = model(in_a, in_b, in_cin, in_sub);
                e.has_lit = cur_has;
                e.lsum    = cur_lsum;
                e.lcout   = cur_lcout;
                e.lovf    = cur_lovf;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_cout  = out_cout;
        end
    end

    // Present one transaction from posedge+1 and hold until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic has, input logic [31:0] lsum,
                        input logic lcout, input logic lovf);
        logic ok;
        int   g;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        cur_has = has; cur_lsum = lsum; cur_lcout = lcout; cur_lovf = lovf;
        ok = 1'b0;
        g  = 0;
        while (!ok && g < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0 || out_valid) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
`ifdef CSEL_OVF_EN
        chk("rst_out_ovf", out_ovf, 0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry across blocks plus latency: visible after the 4th edge.
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int j = 0; j < NBLK; j++) begin
            @(negedge clk);
            chk("latency_valid", out_valid, (j == NBLK - 1));
        end
        drain();

        // Full ripple, carry-in, subtract, mixed carries, back to back.
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        send(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        send(32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
        send(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 32'hACF13568, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        // Backpressure pattern 1,0,0,1,0,1,1,0.
        mode = 1;
        pi   = 0;
        for (int i = 0; i < 8; i++)
            send(32'(i), 32'(i * 32'h100), 1'b0, 1'b0, 1'b1, 32'(i * 32'h101), 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        // Random operands under random backpressure, model only.
        mode = 2;
        for (int i = 0; i < 12; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b0, 32'h0, 1'b0, 1'b0);
        in_valid = 1'b0;
        mode = 0;
        drain();

        // Reset mid-flight with a stalled, partially filled pipe.
        mode = 3;
        @(posedge clk);
        #1;
        send(32'h11, 32'h22, 1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0);
        send(32'h44, 32'h55, 1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0);
        send(32'h66, 32'h77, 1'b0, 1'b0, 1'b1, 32'hDD, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", out_sum, 0);
        chk("async_rst_cout", out_cout, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        mode  = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("post_reset_idle", out_valid, 0);
        end
        @(posedge clk);
        #1;

`ifdef CSEL_OVF_EN
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        send(32'h00000005, 32'h00000007, 1'b0, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor. Operands are split into WIDTH/BLOCK blocks. Each pipeline stage resolves one block:
- Both candidate block sums (carry-in 0 and carry-in 1) are computed in parallel.
- The registered carry from the previous stage selects between them.

It is the wide-datapath successor of the team's 16-bit-split 32-bit carry-select adder, adding carry-in/out, subtract mode, valid/ready flow control and a configurable width and block count. It sits between operand-issue logic and result writeback in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per pipeline stage; NBLK = WIDTH/BLOCK stages, NBLK >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  stage 0 can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in (add mode only)
- in_sub  input  1  1 = compute A - B
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry-out of MSB (subtract: 1 = no borrow)
- out_ovf  output  1  signed overflow (only with CSEL_OVF_EN)

Behaviour:
- Interface clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low. While rst_n = 0, every stage valid bit, every data/carry register and every output is 0, so out_valid = out_sum = out_cout = out_ovf = 0. Reset mid-operation discards all in-flight transactions; nothing emerges after release.
- Operand prep at stage 0:
  - b_eff = in_sub ? ~in_b : in_b
  - c0 = in_sub ? 1 : in_cin (in_cin is ignored when in_sub = 1)
- Stage k (0..NBLK-1):
  - Computes s0 = a_k + b_eff_k + 0 and s1 = a_k + b_eff_k + 1, each BLOCK+1 bits wide.
  - Selects s1 if the incoming carry is 1, else s0. The incoming carry is c0 for k = 0, else the registered carry from stage k-1.
  - Registers the selected BLOCK sum bits, the selected carry, and the still-unprocessed operand blocks k+1..NBLK-1 (skew buffering).
  - Already-resolved low sum bits travel with the transaction.
- Arithmetic: results are modulo 2^WIDTH. out_cout is the carry out of bit WIDTH-1. No combinational path spans more than one block adder plus a mux.
- Flow control: single global enable, en = !out_valid || out_ready.
  - in_ready = en. This is combinationally dependent on out_ready; this dependency is intended.
  - When en = 1, every stage register (valid + data) loads from its predecessor. Stage 0 loads in_valid & in_ready.
  - When en = 0, all stages hold. Bubbles are not collapsed.
  - Transfer at input: in_valid & in_ready at a rising edge. Transfer at output: out_valid & out_ready at a rising edge.
- Latency: a transaction accepted at edge n is on out_* after edge n+NBLK-1 with no stall (NBLK = 1 gives one register stage).
- Throughput: 1 result per cycle while out_ready = 1.
- Outputs are driven directly from final-stage registers. While out_valid = 1 and out_ready = 0, out_* are stable.
- Ordering: strict FIFO order; no loss, duplication or reordering under any out_ready pattern.
- Simultaneous accept and drain in one cycle with a full pipe is legal and sustains full rate.

Optional Feature:
- Macro: CSEL_OVF_EN.
- Defined:
  - The last stage also registers the carry into bit WIDTH-1.
  - out_ovf = carry_into_msb XOR out_cout, i.e. signed overflow for the performed add or subtract.
  - out_ovf is reset to 0 and stalls with the data.
- Undefined: the out_ovf port and its register do not exist.

Test Plan (WIDTH=32, BLOCK=8, NBLK=4, out_ready=1 unless stated):
- Carry across blocks: a=0x0000FFFF, b=0x00000001, cin=0 -> sum=0x00010000, cout=0. out_valid rises after edge n+3 for accept at edge n.
- Full ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1. Also a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1.
- Subtract:
  - a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0.
  - a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
- Backpressure: 8 back-to-back transactions (a=i, b=0x100*i), out_ready pattern 1,0,0,1,0,1,1,0 repeating -> results i+0x100*i appear in order, no drop/duplicate. in_ready = 0 exactly when out_valid = 1 and out_ready = 0. out_sum stable while stalled.
- Reset mid-flight: 3 transactions in flight, rst_n pulled low between edges -> out_valid = 0 immediately (asynchronous). After release with in_valid = 0, out_valid stays 0 for 10 cycles.
- Overflow (CSEL_OVF_EN defined):
  - 0x7FFFFFFF + 1 -> sum=0x80000000, ovf=1.
  - 0x80000000 - 1 (sub) -> sum=0x7FFFFFFF, ovf=1.
  - 5 + 7 -> ovf=0.
